// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 encodings, FSM states and
// operand-signedness helpers. The decode stage imports the same constants.
package muldiv_pkg;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Divide ops all have funct3[2] set; funct3[1] then selects remainder.
  function automatic logic is_div_op(input logic [2:0] f);
    return f[2];
  endfunction

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] f);
    return (f != FUNCT3_MULHU) && (f != FUNCT3_DIVU) && (f != FUNCT3_REMU);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] f);
    return (f == FUNCT3_MUL) || (f == FUNCT3_MULH) ||
           (f == FUNCT3_DIV) || (f == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath. Multiply: shift-add on
// {acc, mplier}. Divide: restoring subtract on {rem, quot}, where the
// dividend is shifted out of the top of quot as quotient bits enter below.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,       // accumulator / partial remainder
  input  logic [XLEN-1:0] lo,       // multiplier / dividend-then-quotient
  input  logic [XLEN-1:0] opnd,     // multiplicand / divisor magnitude
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  // Compute both iteration flavours and pick one by is_div.
  always_comb begin
    // NOTE: every output gets a value on every path so no latch is inferred.
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    fits    = (shifted >= {1'b0, opnd});
    if (is_div) begin
      hi_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], fits};
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, one operation in
// flight. Feeds the register-file write port via result_valid/result/rd_out.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [XLEN-1:0]   hi_q, lo_q, opnd_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_main_q;   // product or quotient needs negating
  logic              neg_rem_q;    // remainder needs negating
  logic              valid_q;

  // Launch-time decode of the live operands.
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, overflow, special_hit;
  logic [XLEN-1:0]   special_result;

  // Datapath step and final correction.
  logic [XLEN-1:0]   hi_next, lo_next;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div_op(op_q)),
    .hi      (hi_q),
    .lo      (lo_q),
    .opnd    (opnd_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // Operand magnitudes, signs and the short-circuit divide cases.
  always_comb begin
    a_neg       = a_is_signed(funct3) & operand_a[XLEN-1];
    b_neg       = b_is_signed(funct3) & operand_b[XLEN-1];
    a_mag       = a_neg ? -operand_a : operand_a;
    b_mag       = b_neg ? -operand_b : operand_b;
    div_zero    = (operand_b == '0);
    overflow    = ((funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM)) &&
                  (operand_a == INT_MIN) && (operand_b == '1);
    special_hit = is_div_op(funct3) && (div_zero || overflow);
    if (div_zero)
      special_result = funct3[1] ? operand_a : '1;
    else
      special_result = funct3[1] ? '0 : operand_a;
  end

  // Sign correction and low/high or quotient/remainder selection.
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_main_q ? -prod : prod;
    quot_fix = neg_main_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q  ? -hi_q : hi_q;
    if (is_div_op(op_q))
      fix_result = op_q[1] ? rem_fix : quot_fix;
    else if (op_q == FUNCT3_MUL)
      fix_result = prod_fix[XLEN-1:0];
    else
      fix_result = prod_fix[2*XLEN-1:XLEN];
  end

  // A kill during DONE must suppress the pulse in that same cycle.
  assign result_valid = valid_q & ~kill;

  // Control FSM with registered busy/result/rd_out outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      op_q       <= FUNCT3_MUL;
      rd_q       <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      valid_q    <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      rd_out     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !kill) begin
            busy <= 1'b1;
            op_q <= funct3;
            rd_q <= rd_in;
            if (special_hit) begin
              result  <= special_result;
              rd_out  <= rd_in;
              valid_q <= 1'b1;
              state   <= DONE;
            end else begin
              hi_q       <= '0;
              lo_q       <= is_div_op(funct3) ? a_mag : b_mag;
              opnd_q     <= is_div_op(funct3) ? b_mag : a_mag;
              neg_main_q <= a_neg ^ b_neg;
              neg_rem_q  <= a_neg;
              count      <= '0;
              state      <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hi_q  <= hi_next;
            lo_q  <= lo_next;
            count <= count + CNT_W'(1);
            if (count == LAST_ITER)
              state <= FIX;
          end
        end
        FIX: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            result  <= fix_result;
            rd_out  <= rd_q;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit. Cycle T is the cycle whose closing edge
// samples start=1; outputs are observed 1 ns after each rising edge.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  rd_in;
  logic        kill;
  logic        busy, result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .funct3       (funct3),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .rd_in        (rd_in),
    .kill         (kill),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .rd_out       (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op in the current cycle T; returns in cycle T+1 with the
  // operand buses scrambled, since the unit must not rely on them.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    start = 1'b1; funct3 = f; operand_a = a; operand_b = b; rd_in = rd;
    tick();
    start = 1'b0; operand_a = $urandom; operand_b = $urandom; rd_in = 5'd31;
  endtask

  // Full op with timing checks; leaves the bench in the first idle cycle.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input bit special);
    launch(f, a, b, rd);
    check({tag, " busy@T+1"}, 32'(busy), 32'd1);
    if (special) begin
      check({tag, " valid@T+1"}, 32'(result_valid), 32'd1);
      check({tag, " result"}, result, exp);
      check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
      tick();
    end else begin
      check({tag, " valid@T+1"}, 32'(result_valid), 32'd0);
      repeat (32) tick();
      check({tag, " valid@T+33"}, 32'(result_valid), 32'd0);
      tick();
      check({tag, " valid@T+34"}, 32'(result_valid), 32'd1);
      check({tag, " busy@T+34"}, 32'(busy), 32'd1);
      check({tag, " result"}, result, exp);
      check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
      tick();
    end
    check({tag, " busy after"}, 32'(busy), 32'd0);
    check({tag, " valid after"}, 32'(result_valid), 32'd0);
    check({tag, " result held"}, result, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'b000;
    operand_a = '0; operand_b = '0; rd_in = '0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(result_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", 32'(rd_out), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Multiply variants.
    run_op("MUL 7*-3", FUNCT3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0);
    run_op("MULH", FUNCT3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 1'b0);
    run_op("MULHU", FUNCT3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("MULHSU", FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 1'b0);

    // Divide variants.
    run_op("DIV -7/2", FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 1'b0);
    run_op("REM -7/2", FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b0);
    run_op("DIVU 100/7", FUNCT3_DIVU, 32'd100, 32'd7, 5'd11, 32'd14, 1'b0);
    run_op("REMU 100/7 rd0", FUNCT3_REMU, 32'd100, 32'd7, 5'd0, 32'd2, 1'b0);

    // Short-circuit cases.
    run_op("DIVU /0", FUNCT3_DIVU, 32'd1234, 32'd0, 5'd12, 32'hFFFF_FFFF, 1'b1);
    run_op("REM /0", FUNCT3_REM, 32'd1234, 32'd0, 5'd13, 32'd1234, 1'b1);
    run_op("DIV ovf", FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1'b1);
    run_op("REM ovf", FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1'b1);

    // Kill in CALC at T+10, then a fresh MUL launched at T+11.
    launch(FUNCT3_DIV, 32'd1000, 32'd3, 5'd16);
    repeat (9) tick();
    kill = 1'b1;
    check("kill busy@T+10", 32'(busy), 32'd1);
    tick();
    kill = 1'b0;
    check("kill busy@T+11", 32'(busy), 32'd0);
    check("kill valid@T+11", 32'(result_valid), 32'd0);
    run_op("MUL 3*4 after kill", FUNCT3_MUL, 32'd3, 32'd4, 5'd17, 32'd12, 1'b0);

    // Kill in DONE suppresses the pulse in that same cycle; start ignored too.
    launch(FUNCT3_DIVU, 32'd55, 32'd0, 5'd18);
    kill = 1'b1; start = 1'b1;
    #1;
    check("kill in DONE valid", 32'(result_valid), 32'd0);
    tick();
    kill = 1'b0; start = 1'b0;
    check("kill in DONE busy after", 32'(busy), 32'd0);
    tick();
    check("start with kill ignored", 32'(busy), 32'd0);

    // Asynchronous reset mid-multiply at T+20.
    launch(FUNCT3_MUL, 32'd5, 32'd6, 5'd19);
    repeat (19) tick();
    #2 rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst valid", 32'(result_valid), 32'd0);
    check("async rst result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    run_op("MUL after rst", FUNCT3_MUL, 32'd5, 32'd6, 5'd20, 32'd30, 1'b0);

    // start held high: accept at S, S+35, S+70; pulses at S+34 and S+69.
    start = 1'b1; funct3 = FUNCT3_MULHU; operand_a = 32'h0001_0000;
    operand_b = 32'h0003_0000; rd_in = 5'd21;
    for (int i = 1; i <= 75; i++) begin
      tick();
      check($sformatf("b2b valid@S+%0d", i), 32'(result_valid),
            32'((i == 34) || (i == 69)));
      check($sformatf("b2b busy@S+%0d", i), 32'(busy),
            32'(!((i == 35) || (i == 70))));
      if (i == 34 || i == 69) check($sformatf("b2b result@S+%0d", i), result, 32'd3);
    end
    start = 1'b0;
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("b2b drained", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
